puf_chal_seq: RTL and testbench

- Challenge sequencer and response collector that sits directly upstream of the RO-PUF evaluation core, replacing that core's hard-wired challenge.
- Per run it issues RESP_BITS successive challenges, starting from a host-supplied seed.
- For each challenge it pulses an evaluation start and waits for the core's done strobe. It then shifts the core's comparator bit into a response word.
- The finished word goes to the host over a valid/ready handshake.

---
 rtl/puf_chal_seq.sv | 151 +++++++++++++++
 tb/tb_puf_chal_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_chal_seq.sv
// puf_chal_seq: challenge sequencer and response collector for an RO-PUF core.
// Each run issues RESP_BITS challenges starting from a host seed. For each one
// it pulses eval_start and waits for eval_done, then shifts resp_bit into a word
// (first bit ends up in the MSB). The finished word is offered on a valid/ready
// handshake. A watchdog aborts a run whose core never answers.
// Optional build macro PUF_CHAL_LFSR_EN: challenges advance as a Fibonacci LFSR
// (x^8+x^6+x^5+x^4+1 for CHAL_W=8) and a zero seed is loaded as 1. Without the
// macro the challenge is a plain wrapping incrementer and seed 0 is legal.
module puf_chal_seq #(
  parameter int CHAL_W    = 8,
  parameter int RESP_BITS = 32,
  parameter int TIMEOUT   = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAL_W-1:0]    seed,
  output logic [CHAL_W-1:0]    chall,
  output logic                 eval_start,
  input  logic                 eval_done,
  input  logic                 resp_bit,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CNT_W = $clog2(RESP_BITS + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t                 state_q;
  logic [CHAL_W-1:0]      chall_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [WD_W-1:0]        wdog_q;
  logic [RESP_BITS-1:0]   shift_q;
  logic [RESP_BITS-1:0]   resp_data_q;
  logic                   eval_start_q;
  logic                   resp_valid_q;
  logic                   busy_q;
  logic                   timeout_err_q;

  logic [CHAL_W-1:0]      seed_ld_d;
  logic [CHAL_W-1:0]      chall_adv_d;
  logic [RESP_BITS-1:0]   shift_d;

  // First challenge of a run; the LFSR variant must never start from zero.
  function automatic logic [CHAL_W-1:0] chall_load(input logic [CHAL_W-1:0] s);
`ifdef PUF_CHAL_LFSR_EN
    return (s == '0) ? CHAL_W'(1) : s;
`else
    return s;
`endif
  endfunction

  // Next challenge after the current one has been evaluated.
  function automatic logic [CHAL_W-1:0] chall_next(input logic [CHAL_W-1:0] c);
`ifdef PUF_CHAL_LFSR_EN
    return {c[CHAL_W-2:0], c[CHAL_W-1] ^ c[CHAL_W-3] ^ c[CHAL_W-4] ^ c[CHAL_W-5]};
`else
    return c + CHAL_W'(1);
`endif
  endfunction

  assign seed_ld_d   = chall_load(seed);
  assign chall_adv_d = chall_next(chall_q);
  assign shift_d     = {shift_q[RESP_BITS-2:0], resp_bit};

  // Run sequencer: one FSM, all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      chall_q       <= '0;
      bit_cnt_q     <= '0;
      wdog_q        <= '0;
      shift_q       <= '0;
      resp_data_q   <= '0;
      eval_start_q  <= 1'b0;
      resp_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      eval_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            chall_q       <= seed_ld_d;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            timeout_err_q <= 1'b0;
            eval_start_q  <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          wdog_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (eval_done) begin
            // A late answer on the timeout cycle still counts.
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(RESP_BITS - 1)) begin
              resp_data_q  <= shift_d;
              resp_valid_q <= 1'b1;
              state_q      <= OUTPUT;
            end else begin
              chall_q      <= chall_adv_d;
              eval_start_q <= 1'b1;
              state_q      <= ISSUE;
            end
          end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            // Abandon the run; resp_data keeps the last delivered word.
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        OUTPUT: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign chall       = chall_q;
  assign eval_start  = eval_start_q;
  assign resp_data   = resp_data_q;
  assign resp_valid  = resp_valid_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_puf_chal_seq.sv
// Testbench for puf_chal_seq: behavioural PUF core answering eval_start with a
// parity-of-challenge bit after a programmable latency, plus scoreboards of
// expected challenges and expected response words.
module tb_puf_chal_seq;

  localparam int CHAL_W    = 8;
  localparam int RESP_BITS = 32;
  localparam int TIMEOUT   = 100;

  logic                 clk        = 1'b0;
  logic                 rst        = 1'b0;
  logic                 start      = 1'b0;
  logic [CHAL_W-1:0]    seed       = '0;
  logic                 eval_done  = 1'b0;
  logic                 resp_bit   = 1'b0;
  logic                 resp_ready = 1'b0;
  logic [CHAL_W-1:0]    chall;
  logic                 eval_start;
  logic [RESP_BITS-1:0] resp_data;
  logic                 resp_valid;
  logic                 busy;
  logic                 timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [CHAL_W-1:0]    exp_chall_q[$];
  logic [RESP_BITS-1:0] exp_resp_q[$];

  int   puf_lat  = 4;
  int   hang_idx = -1;
  int   ev_cnt   = 0;
  int   ev_cyc   = 0;
  int   puf_cnt  = 0;
  logic puf_pend = 1'b0;
  logic [CHAL_W-1:0] puf_ch = '0;
  int   t_start  = 0;

  puf_chal_seq #(
    .CHAL_W   (CHAL_W),
    .RESP_BITS(RESP_BITS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .chall      (chall),
    .eval_start (eval_start),
    .eval_done  (eval_done),
    .resp_bit   (resp_bit),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CHAL_W-1:0] mdl_load(input logic [CHAL_W-1:0] s);
`ifdef PUF_CHAL_LFSR_EN
    return (s == 8'h00) ? 8'h01 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [CHAL_W-1:0] mdl_adv(input logic [CHAL_W-1:0] c);
`ifdef PUF_CHAL_LFSR_EN
    return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
`else
    return c + 8'd1;
`endif
  endfunction

  // PUF core model: checks each issued challenge and answers after puf_lat cycles.
  always @(negedge clk) begin
    eval_done = 1'b0;
    if (!rst) begin
      puf_pend = 1'b0;
    end else begin
      if (puf_pend) begin
        if (puf_cnt <= 1) begin
          chk("chall_hold", chall, puf_ch);
          eval_done = 1'b1;
          resp_bit  = ^puf_ch;
          puf_pend  = 1'b0;
        end else begin
          puf_cnt--;
        end
      end
      if (eval_start) begin
        if (exp_chall_q.size() == 0) chk("extra_eval_start", 1, 0);
        else chk("chall", chall, exp_chall_q.pop_front());
        if (ev_cnt != hang_idx) begin
          puf_pend = 1'b1;
          puf_cnt  = puf_lat;
          puf_ch   = chall;
        end
        ev_cnt++;
        ev_cyc = cyc;
      end
    end
  end

  // Queue expected challenges/word, then present start for one cycle.
  task automatic launch(input logic [CHAL_W-1:0] sd, input int lat, input int hang);
    logic [CHAL_W-1:0]    c;
    logic [RESP_BITS-1:0] w;
    int n;
    c = mdl_load(sd);
    w = '0;
    n = (hang < 0) ? RESP_BITS : hang + 1;
    for (int i = 0; i < RESP_BITS; i++) begin
      if (i < n) exp_chall_q.push_back(c);
      w = {w[RESP_BITS-2:0], ^c};
      c = mdl_adv(c);
    end
    if (hang < 0) exp_resp_q.push_back(w);
    puf_lat  = lat;
    hang_idx = hang;
    ev_cnt   = 0;
    seed     = sd;
    start    = 1'b1;
    t_start  = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for the response, check it, apply bp cycles of backpressure, hand it off.
  task automatic collect(input int bp, input int want_lat);
    int t;
    logic [RESP_BITS-1:0] held;
    t = 0;
    while (!resp_valid && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (!resp_valid) begin
      chk("valid_timeout", 0, 1);
      exp_resp_q.delete();
      return;
    end
    if (want_lat > 0) chk("latency", cyc - t_start, want_lat);
    chk("ev_count", ev_cnt, RESP_BITS);
    if (exp_resp_q.size() == 0) chk("resp_unexpected", 1, 0);
    else chk("resp_data", resp_data, exp_resp_q.pop_front());
    held = resp_data;
    for (int i = 0; i < bp; i++) begin
      start = i[0];
      seed  = 8'h33;
      @(negedge clk);
      chk("bp_hold", {resp_valid, resp_data}, {1'b1, held});
    end
    start      = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_handshake", {resp_valid, busy}, 2'b00);
    @(negedge clk);
    chk("idle_stay", {busy, eval_start}, 2'b00);
  endtask

  initial begin
    int t;
    logic saw;
    logic [RESP_BITS-1:0] prev_data;

    // Reset held low with start toggling.
    rst  = 1'b0;
    seed = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      start = ~start;
      @(negedge clk);
      chk("rst_out", {chall, resp_data, eval_start, resp_valid, busy, timeout_err}, 64'd0);
    end
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_after_rst", {busy, resp_valid}, 2'b00);
    chk("no_eval_in_rst", ev_cnt, 0);

    // Basic run with long backpressure and ignored start pulses.
    launch(8'h69, 4, -1);
    collect(20, 0);

    // Wrap-around through 0xFF.
    launch(8'hF0, 2, -1);
    collect(0, 0);

    // Ready held high before valid appears.
    resp_ready = 1'b1;
    launch(8'hC3, 3, -1);
    collect(0, 0);

    // Timeout on bit 5.
    prev_data = resp_data;
    launch(8'h40, 2, 5);
    t   = 0;
    saw = 1'b0;
    while (t < 400) begin
      @(negedge clk);
      t++;
      if (resp_valid) saw = 1'b1;
      if (!busy) break;
    end
    chk("to_busy", busy, 0);
    chk("to_err", timeout_err, 1);
    chk("to_wait_cycles", cyc - ev_cyc, TIMEOUT + 1);
    chk("to_no_valid", saw, 0);
    chk("to_data_kept", resp_data, prev_data);
    chk("to_ev_count", ev_cnt, 6);
    repeat (3) @(negedge clk);
    chk("to_sticky", timeout_err, 1);

    // New start clears the error; minimum-latency run from seed 0.
    launch(8'h00, 1, -1);
    chk("to_clear", timeout_err, 0);
    collect(3, 2 * RESP_BITS + 1);

`ifdef PUF_CHAL_LFSR_EN
    launch(8'h80, 1, -1);
    collect(0, 2 * RESP_BITS + 1);
`endif

    // Asynchronous reset in the middle of bit 10.
    launch(8'h11, 3, -1);
    t = 0;
    while (ev_cnt < 11 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("mid_reach", ev_cnt >= 11, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst", {chall, resp_data, eval_start, resp_valid, busy, timeout_err}, 64'd0);
    exp_chall_q.delete();
    exp_resp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resp_valid || busy) saw = 1'b1;
    end
    chk("mid_quiet", saw, 0);

    // A clean run after the aborted one.
    launch(8'h7E, 2, -1);
    collect(2, 0);

    chk("chall_q_left", exp_chall_q.size(), 0);
    chk("resp_q_left", exp_resp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
